// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode / ALU-op encodings, FSM state type and exception codes
// shared by the control-decode stage and its combinational decoder.
package ctrl_pkg;

    // Opcodes (insn[31:27])
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    // ALU operations (insn[6:2] for R-type)
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRA  = 5'b00101;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    // Stage FSM: normal decode, or parked while the multdiv unit works
    typedef enum logic {
        ST_DECODE  = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_e;

    // Exception codes written to the status register
    localparam logic [2:0] EXC_MUL     = 3'd4;
    localparam logic [2:0] EXC_DIV     = 3'd5;
    localparam logic [2:0] EXC_TIMEOUT = 3'd6;

endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: purely combinational instruction-to-control decode.
// Non-writing instructions still present rd on o_wr_reg; o_rwe is what
// qualifies a register write, and it is never set for destination 0.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 5,
    parameter int ALUOP_W     = 5,
    parameter int REG_ADDR_W  = 5,
    parameter int RSTATUS_REG = 30
) (
    input  logic [31:0]           i_insn,
    output logic                  o_rdst,
    output logic                  o_rwe,
    output logic                  o_rwd,
    output logic                  o_dmwe,
    output logic                  o_alu_inb,
    output logic [ALUOP_W-1:0]    o_alu_op,
    output logic                  o_is_branch,
    output logic                  o_is_jump,
    output logic [REG_ADDR_W-1:0] o_wr_reg,
    output logic                  o_is_md,
    output logic                  o_md_div
);

    logic [OPCODE_W-1:0]   w_opcode;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [ALUOP_W-1:0]    w_alu_field;
    logic                  w_writes_rd;
    logic                  w_unused_insn;

    assign w_opcode    = i_insn[31 -: OPCODE_W];
    assign w_rd        = i_insn[31-OPCODE_W -: REG_ADDR_W];
    assign w_alu_field = i_insn[2 +: ALUOP_W];
    // rs/rt/immediate are consumed by the datapath, not by control
    assign w_unused_insn = ^{i_insn[31-OPCODE_W-REG_ADDR_W : 2+ALUOP_W], i_insn[1:0]};

    // Opcode decode; register write is suppressed for destination 0
    always_comb begin
        o_rdst      = 1'b0;
        o_rwd       = 1'b0;
        o_dmwe      = 1'b0;
        o_alu_inb   = 1'b0;
        o_alu_op    = ALUOP_W'(ALU_ADD);
        o_is_branch = 1'b0;
        o_is_jump   = 1'b0;
        o_wr_reg    = w_rd;
        o_is_md     = 1'b0;
        o_md_div    = 1'b0;
        w_writes_rd = 1'b0;
        case (w_opcode)
            OPCODE_W'(OP_RTYPE): begin
                w_writes_rd = 1'b1;
                o_alu_op    = w_alu_field;
                o_md_div    = (w_alu_field == ALUOP_W'(ALU_DIV));
                o_is_md     = (w_alu_field == ALUOP_W'(ALU_MUL)) || o_md_div;
            end
            OPCODE_W'(OP_ADDI): begin
                w_writes_rd = 1'b1;
                o_alu_inb   = 1'b1;
            end
            OPCODE_W'(OP_LW): begin
                w_writes_rd = 1'b1;
                o_alu_inb   = 1'b1;
                o_rwd       = 1'b1;
            end
            OPCODE_W'(OP_SW): begin
                o_alu_inb = 1'b1;
                o_dmwe    = 1'b1;
                o_rdst    = 1'b1;
            end
            OPCODE_W'(OP_BNE), OPCODE_W'(OP_BLT): begin
                o_is_branch = 1'b1;
                o_rdst      = 1'b1;
                o_alu_op    = ALUOP_W'(ALU_SUB);
            end
            OPCODE_W'(OP_J), OPCODE_W'(OP_BEX): begin
                o_is_jump = 1'b1;
            end
            OPCODE_W'(OP_JAL): begin
                o_is_jump   = 1'b1;
                w_writes_rd = 1'b1;
                o_wr_reg    = {REG_ADDR_W{1'b1}};
            end
            OPCODE_W'(OP_JR): begin
                o_is_jump = 1'b1;
                o_rdst    = 1'b1;
            end
            OPCODE_W'(OP_SETX): begin
                w_writes_rd = 1'b1;
                o_wr_reg    = REG_ADDR_W'(RSTATUS_REG);
            end
            default: begin
                // unknown opcode: nop, every enable stays low
            end
        endcase
        o_rwe = w_writes_rd && (o_wr_reg != '0);
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered control decode with mul/div sequencing.
// Optional macro CTRL_EXC_EN: multdiv exceptions and timeouts write an
// exception code into the status register.
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 5,
    parameter int ALUOP_W     = 5,
    parameter int REG_ADDR_W  = 5,
    parameter int MD_TIMEOUT  = 40,
    parameter int RSTATUS_REG = 30
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [31:0]           insn_in,
    input  logic                  insn_valid,
    input  logic                  md_ready,
    input  logic                  md_exception,
    output logic                  ctrl_valid,
    output logic                  rdst,
    output logic                  rwe,
    output logic                  rwd,
    output logic                  dmwe,
    output logic                  alu_inb,
    output logic [ALUOP_W-1:0]    alu_op,
    output logic                  is_branch,
    output logic                  is_jump,
    output logic [REG_ADDR_W-1:0] wr_reg,
    output logic                  md_start,
    output logic                  md_is_div,
    output logic                  stall_out,
    output logic                  md_timeout,
    output logic                  exc_valid,
    output logic [2:0]            exc_code
);

    localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

    logic                  w_dec_rdst, w_dec_rwe, w_dec_rwd, w_dec_dmwe, w_dec_alu_inb;
    logic [ALUOP_W-1:0]    w_dec_alu_op;
    logic                  w_dec_is_branch, w_dec_is_jump, w_dec_is_md, w_dec_md_div;
    logic [REG_ADDR_W-1:0] w_dec_wr_reg;

    state_e                r_state, w_state_next;
    logic [CNT_W-1:0]      r_count;
    logic [REG_ADDR_W-1:0] r_md_rd;
    logic [ALUOP_W-1:0]    r_md_alu;
    logic                  r_md_div;
    logic                  w_md_accept, w_timeout_hit;

    logic                  w_ctrl_valid_next, w_rdst_next, w_rwe_next, w_rwd_next;
    logic                  w_dmwe_next, w_alu_inb_next, w_is_branch_next, w_is_jump_next;
    logic [ALUOP_W-1:0]    w_alu_op_next;
    logic [REG_ADDR_W-1:0] w_wr_reg_next;
    logic                  w_md_start_next, w_md_is_div_next, w_stall_next, w_md_timeout_next;
    logic                  w_exc_valid_next;
    logic [2:0]            w_exc_code_next;

    ctrl_decode_comb #(
        .OPCODE_W    (OPCODE_W),
        .ALUOP_W     (ALUOP_W),
        .REG_ADDR_W  (REG_ADDR_W),
        .RSTATUS_REG (RSTATUS_REG)
    ) u_decode (
        .i_insn      (insn_in),
        .o_rdst      (w_dec_rdst),
        .o_rwe       (w_dec_rwe),
        .o_rwd       (w_dec_rwd),
        .o_dmwe      (w_dec_dmwe),
        .o_alu_inb   (w_dec_alu_inb),
        .o_alu_op    (w_dec_alu_op),
        .o_is_branch (w_dec_is_branch),
        .o_is_jump   (w_dec_is_jump),
        .o_wr_reg    (w_dec_wr_reg),
        .o_is_md     (w_dec_is_md),
        .o_md_div    (w_dec_md_div)
    );

    assign w_md_accept   = (r_state == ST_DECODE) && insn_valid && w_dec_is_md;
    assign w_timeout_hit = (r_count == CNT_W'(MD_TIMEOUT));

    // Next state: park on a mul/div, return on completion or timeout
    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_DECODE) begin
            if (w_md_accept) w_state_next = ST_MD_WAIT;
        end else begin
            if (md_ready || w_timeout_hit) w_state_next = ST_DECODE;
        end
    end

    // State register, saturating wait counter and captured mul/div operands
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_DECODE;
            r_count  <= '0;
            r_md_rd  <= '0;
            r_md_alu <= '0;
            r_md_div <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_md_accept) begin
                r_count  <= '0;
                r_md_rd  <= w_dec_wr_reg;
                r_md_alu <= w_dec_alu_op;
                r_md_div <= w_dec_md_div;
            end else if (r_state == ST_MD_WAIT) begin
                if (r_count != {CNT_W{1'b1}}) r_count <= r_count + 1'b1;
            end else begin
                r_count <= '0;
            end
        end
    end

    // Output values to register: decode, mul/div issue/wait, writeback or abort
    always_comb begin
        w_ctrl_valid_next = 1'b0;
        w_rdst_next       = 1'b0;
        w_rwe_next        = 1'b0;
        w_rwd_next        = 1'b0;
        w_dmwe_next       = 1'b0;
        w_alu_inb_next    = 1'b0;
        w_alu_op_next     = '0;
        w_is_branch_next  = 1'b0;
        w_is_jump_next    = 1'b0;
        w_wr_reg_next     = '0;
        w_md_start_next   = 1'b0;
        w_md_is_div_next  = 1'b0;
        w_stall_next      = 1'b0;
        w_md_timeout_next = 1'b0;
        w_exc_valid_next  = 1'b0;
        w_exc_code_next   = '0;
        if (r_state == ST_DECODE) begin
            if (w_md_accept) begin
                w_md_start_next  = 1'b1;
                w_md_is_div_next = w_dec_md_div;
                w_stall_next     = 1'b1;
            end else if (insn_valid) begin
                w_ctrl_valid_next = 1'b1;
                w_rdst_next       = w_dec_rdst;
                w_rwe_next        = w_dec_rwe;
                w_rwd_next        = w_dec_rwd;
                w_dmwe_next       = w_dec_dmwe;
                w_alu_inb_next    = w_dec_alu_inb;
                w_alu_op_next     = w_dec_alu_op;
                w_is_branch_next  = w_dec_is_branch;
                w_is_jump_next    = w_dec_is_jump;
                w_wr_reg_next     = w_dec_wr_reg;
            end
        end else if (md_ready) begin
            // completion has priority over a coincident timeout
            w_ctrl_valid_next = 1'b1;
            w_alu_op_next     = r_md_alu;
`ifdef CTRL_EXC_EN
            if (md_exception) begin
                w_wr_reg_next    = REG_ADDR_W'(RSTATUS_REG);
                w_rwe_next       = 1'b1;
                w_exc_valid_next = 1'b1;
                w_exc_code_next  = r_md_div ? EXC_DIV : EXC_MUL;
            end else begin
                w_wr_reg_next = r_md_rd;
                w_rwe_next    = (r_md_rd != '0);
            end
`else
            w_wr_reg_next = r_md_rd;
            w_rwe_next    = (r_md_rd != '0);
`endif
        end else if (w_timeout_hit) begin
            w_ctrl_valid_next = 1'b1;
            w_md_timeout_next = 1'b1;
`ifdef CTRL_EXC_EN
            w_wr_reg_next    = REG_ADDR_W'(RSTATUS_REG);
            w_rwe_next       = 1'b1;
            w_exc_valid_next = 1'b1;
            w_exc_code_next  = EXC_TIMEOUT;
`endif
        end else begin
            w_stall_next     = 1'b1;
            w_md_is_div_next = r_md_div;
        end
    end

    // Output registers: control is valid the cycle after acceptance
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_valid <= 1'b0;
            rdst       <= 1'b0;
            rwe        <= 1'b0;
            rwd        <= 1'b0;
            dmwe       <= 1'b0;
            alu_inb    <= 1'b0;
            alu_op     <= '0;
            is_branch  <= 1'b0;
            is_jump    <= 1'b0;
            wr_reg     <= '0;
            md_start   <= 1'b0;
            md_is_div  <= 1'b0;
            stall_out  <= 1'b0;
            md_timeout <= 1'b0;
        end else begin
            ctrl_valid <= w_ctrl_valid_next;
            rdst       <= w_rdst_next;
            rwe        <= w_rwe_next;
            rwd        <= w_rwd_next;
            dmwe       <= w_dmwe_next;
            alu_inb    <= w_alu_inb_next;
            alu_op     <= w_alu_op_next;
            is_branch  <= w_is_branch_next;
            is_jump    <= w_is_jump_next;
            wr_reg     <= w_wr_reg_next;
            md_start   <= w_md_start_next;
            md_is_div  <= w_md_is_div_next;
            stall_out  <= w_stall_next;
            md_timeout <= w_md_timeout_next;
        end
    end

`ifdef CTRL_EXC_EN
    // Exception report registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exc_valid <= 1'b0;
            exc_code  <= '0;
        end else begin
            exc_valid <= w_exc_valid_next;
            exc_code  <= w_exc_code_next;
        end
    end
`else
    logic w_unused_exc;
    assign w_unused_exc = ^{md_exception, w_exc_valid_next, w_exc_code_next};
    assign exc_valid    = 1'b0;
    assign exc_code     = '0;
`endif

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb_ctrl_decode_stage: directed vector table, hand-written mul/div
// sequences and a randomized stream checked against a behavioural model.
`timescale 1ns/1ps
module tb_ctrl_decode_stage;

    localparam logic [4:0] T_R    = 5'b00000;
    localparam logic [4:0] T_J    = 5'b00001;
    localparam logic [4:0] T_BNE  = 5'b00010;
    localparam logic [4:0] T_JAL  = 5'b00011;
    localparam logic [4:0] T_JR   = 5'b00100;
    localparam logic [4:0] T_ADDI = 5'b00101;
    localparam logic [4:0] T_BLT  = 5'b00110;
    localparam logic [4:0] T_SW   = 5'b00111;
    localparam logic [4:0] T_LW   = 5'b01000;
    localparam logic [4:0] T_SETX = 5'b10101;
    localparam logic [4:0] T_BEX  = 5'b10110;
    localparam int TMO = 40;
`ifdef CTRL_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] insn_in;
    logic        insn_valid, md_ready, md_exception;
    logic        ctrl_valid, rdst, rwe, rwd, dmwe, alu_inb, is_branch, is_jump;
    logic [4:0]  alu_op, wr_reg;
    logic        md_start, md_is_div, stall_out, md_timeout, exc_valid;
    logic [2:0]  exc_code;

    ctrl_decode_stage dut (
        .clock(clock), .reset_n(reset_n), .insn_in(insn_in), .insn_valid(insn_valid),
        .md_ready(md_ready), .md_exception(md_exception), .ctrl_valid(ctrl_valid),
        .rdst(rdst), .rwe(rwe), .rwd(rwd), .dmwe(dmwe), .alu_inb(alu_inb),
        .alu_op(alu_op), .is_branch(is_branch), .is_jump(is_jump), .wr_reg(wr_reg),
        .md_start(md_start), .md_is_div(md_is_div), .stall_out(stall_out),
        .md_timeout(md_timeout), .exc_valid(exc_valid), .exc_code(exc_code)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       ctrl_valid, rdst, rwe, rwd, dmwe, alu_inb;
        logic [4:0] alu_op;
        logic       is_branch, is_jump;
        logic [4:0] wr_reg;
        logic       md_start, md_is_div, stall_out, md_timeout, exc_valid;
        logic [2:0] exc_code;
    } out_t;

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic        valid;
        out_t        exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[16];
    logic [4:0] known_ops[11];
    int stall_cnt;

    function automatic out_t sample();
        out_t o;
        o.ctrl_valid = ctrl_valid; o.rdst = rdst; o.rwe = rwe; o.rwd = rwd;
        o.dmwe = dmwe; o.alu_inb = alu_inb; o.alu_op = alu_op;
        o.is_branch = is_branch; o.is_jump = is_jump; o.wr_reg = wr_reg;
        o.md_start = md_start; o.md_is_div = md_is_div; o.stall_out = stall_out;
        o.md_timeout = md_timeout; o.exc_valid = exc_valid; o.exc_code = exc_code;
        return o;
    endfunction

    function automatic out_t ev(input logic cv, input logic rs, input logic we, input logic wd,
                                input logic mw, input logic inb, input logic [4:0] aop,
                                input logic br, input logic jmp, input logic [4:0] wr);
        out_t o;
        o = '0;
        o.ctrl_valid = cv; o.rdst = rs; o.rwe = we; o.rwd = wd; o.dmwe = mw;
        o.alu_inb = inb; o.alu_op = aop; o.is_branch = br; o.is_jump = jmp; o.wr_reg = wr;
        return o;
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [16:0] low);
        return {op, rd, rs, low};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] aop);
        return {T_R, rd, rs, rt, 5'd0, aop, 2'b00};
    endfunction

    // Reference decode written from the instruction-class rules
    function automatic out_t model_decode(input logic [31:0] ins);
        out_t e;
        logic [4:0] op;
        logic writes;
        op = ins[31:27];
        e = '0;
        e.ctrl_valid = 1'b1;
        e.wr_reg     = ins[26:22];
        writes       = op inside {T_R, T_ADDI, T_LW, T_JAL, T_SETX};
        if (op == T_JAL)  e.wr_reg = 5'd31;
        if (op == T_SETX) e.wr_reg = 5'd30;
        e.rwe       = writes && (e.wr_reg != 5'd0);
        e.rdst      = op inside {T_SW, T_BNE, T_BLT, T_JR};
        e.rwd       = (op == T_LW);
        e.dmwe      = (op == T_SW);
        e.alu_inb   = op inside {T_ADDI, T_LW, T_SW};
        e.is_branch = op inside {T_BNE, T_BLT};
        e.is_jump   = op inside {T_J, T_JAL, T_JR, T_BEX};
        e.alu_op    = e.is_branch ? 5'd1 : ((op == T_R) ? ins[6:2] : 5'd0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input out_t act, input out_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Issue one mul/div; md_ready rises after `lat` idle wait cycles (never if lat>=TMO+1)
    task automatic md_seq(input logic [31:0] ins, input int lat, input logic exc,
                          input string tag, output int stalls);
        out_t exp;
        logic [4:0] rd, aop;
        logic div;
        rd = ins[26:22]; aop = ins[6:2]; div = (aop == 5'd7);
        stalls = 0;
        insn_in = ins; insn_valid = 1'b1; md_ready = 1'b0; md_exception = 1'b0;
        tick();
        exp = '0; exp.md_start = 1'b1; exp.md_is_div = div; exp.stall_out = 1'b1;
        chk({tag, "_start"}, sample(), exp);
        if (stall_out) stalls++;
        for (int w = 1; w <= TMO + 1; w++) begin
            logic rdy;
            rdy          = (w == lat + 1);
            insn_in      = $urandom;
            insn_valid   = 1'($urandom_range(0, 1));
            md_ready     = rdy;
            md_exception = rdy ? exc : 1'($urandom_range(0, 1));
            tick();
            exp = '0;
            if (rdy) begin
                exp.ctrl_valid = 1'b1;
                exp.alu_op     = aop;
                if (EXC_EN && exc) begin
                    exp.wr_reg = 5'd30; exp.rwe = 1'b1;
                    exp.exc_valid = 1'b1; exp.exc_code = div ? 3'd5 : 3'd4;
                end else begin
                    exp.wr_reg = rd; exp.rwe = (rd != 5'd0);
                end
                chk({tag, "_done"}, sample(), exp);
                break;
            end else if (w == TMO + 1) begin
                exp.ctrl_valid = 1'b1;
                exp.md_timeout = 1'b1;
                if (EXC_EN) begin
                    exp.wr_reg = 5'd30; exp.rwe = 1'b1;
                    exp.exc_valid = 1'b1; exp.exc_code = 3'd6;
                end
                chk({tag, "_timeout"}, sample(), exp);
                break;
            end else begin
                exp.stall_out = 1'b1; exp.md_is_div = div;
                chk({tag, "_wait"}, sample(), exp);
                if (stall_out) stalls++;
            end
        end
        insn_valid = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
        $display("[TB] %s insn=%h lat=%0d exc=%0d stalls=%0d", tag, ins, lat, exc, stalls);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        insn_in = '0; insn_valid = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
        reset_n = 1'b0;
        known_ops = '{T_R, T_J, T_BNE, T_JAL, T_JR, T_ADDI, T_BLT, T_SW, T_LW, T_SETX, T_BEX};

        //                 name        insn                                valid  cv rs we wd mw ib aop  br jp wr
        vecs[0]  = '{"addi_r3",  mk(T_ADDI, 5'd3, 5'd1, 17'h00015), 1'b1, ev(1,0,1,0,0,1,5'd0,0,0,5'd3)};
        vecs[1]  = '{"sw_r4",    mk(T_SW,   5'd4, 5'd2, 17'h00008), 1'b1, ev(1,1,0,0,1,1,5'd0,0,0,5'd4)};
        vecs[2]  = '{"lw_r5",    mk(T_LW,   5'd5, 5'd2, 17'h00008), 1'b1, ev(1,0,1,1,0,1,5'd0,0,0,5'd5)};
        vecs[3]  = '{"add_r0",   rtype(5'd0, 5'd1, 5'd2, 5'd0),     1'b1, ev(1,0,0,0,0,0,5'd0,0,0,5'd0)};
        vecs[4]  = '{"and_r9",   rtype(5'd9, 5'd1, 5'd2, 5'd2),     1'b1, ev(1,0,1,0,0,0,5'd2,0,0,5'd9)};
        vecs[5]  = '{"sra_r12",  rtype(5'd12, 5'd3, 5'd4, 5'd5),    1'b1, ev(1,0,1,0,0,0,5'd5,0,0,5'd12)};
        vecs[6]  = '{"j",        mk(T_J,    5'd2, 5'd0, 17'h01234), 1'b1, ev(1,0,0,0,0,0,5'd0,0,1,5'd2)};
        vecs[7]  = '{"bne_r6",   mk(T_BNE,  5'd6, 5'd7, 17'h00004), 1'b1, ev(1,1,0,0,0,0,5'd1,1,0,5'd6)};
        vecs[8]  = '{"jal",      mk(T_JAL,  5'd0, 5'd0, 17'h00100), 1'b1, ev(1,0,1,0,0,0,5'd0,0,1,5'd31)};
        vecs[9]  = '{"jr_r31",   mk(T_JR,  5'd31, 5'd0, 17'h00000), 1'b1, ev(1,1,0,0,0,0,5'd0,0,1,5'd31)};
        vecs[10] = '{"blt_r8",   mk(T_BLT,  5'd8, 5'd9, 17'h1FFFC), 1'b1, ev(1,1,0,0,0,0,5'd1,1,0,5'd8)};
        vecs[11] = '{"bex",      mk(T_BEX,  5'd0, 5'd0, 17'h00040), 1'b1, ev(1,0,0,0,0,0,5'd0,0,1,5'd0)};
        vecs[12] = '{"setx",     mk(T_SETX, 5'd0, 5'd0, 17'h00007), 1'b1, ev(1,0,1,0,0,0,5'd0,0,0,5'd30)};
        vecs[13] = '{"unknown",  mk(5'h1F, 5'd10, 5'd1, 17'h00003), 1'b1, ev(1,0,0,0,0,0,5'd0,0,0,5'd10)};
        vecs[14] = '{"invalid",  mk(T_ADDI, 5'd3, 5'd1, 17'h00001), 1'b0, '0};
        vecs[15] = '{"lw_r0",    mk(T_LW,   5'd0, 5'd2, 17'h00000), 1'b1, ev(1,0,0,1,0,1,5'd0,0,0,5'd0)};

        // Reset state
        tick(); tick();
        chk("reset_state", sample(), '0);
        $display("[TB] reset held: outputs=%h", sample());
        reset_n = 1'b1;

        // Directed vector table (sw then lw run back to back)
        for (int i = 0; i < 16; i++) begin
            insn_in = vecs[i].insn; insn_valid = vecs[i].valid;
            tick();
            chk(vecs[i].name, sample(), vecs[i].exp);
            $display("[TB] vec %s insn=%h valid=%0d out=%h", vecs[i].name, vecs[i].insn,
                     vecs[i].valid, sample());
        end

        // Reset asserted mid-stream clears outputs without waiting for an edge
        insn_in = mk(T_ADDI, 5'd4, 5'd1, 17'h00002); insn_valid = 1'b1;
        tick();
        #2 reset_n = 1'b0;
        #1 chk("async_reset", sample(), '0);
        tick();
        chk("reset_held", sample(), '0);
        reset_n = 1'b1;
        insn_in = 32'h28C00000 | 32'h00000ABC; insn_valid = 1'b1;
        tick();
        chk("addi_after_reset", sample(), ev(1,0,1,0,0,1,5'd0,0,0,5'd3));
        $display("[TB] reset mid-stream then addi r3: out=%h", sample());
        insn_valid = 1'b0;

        // div rd=7, md_ready after 10 wait cycles
        md_seq(rtype(5'd7, 5'd1, 5'd2, 5'd7), 10, 1'b0, "div_r7", stall_cnt);
        chk_int("div_stall_cycles", stall_cnt, 11);

        // mul that never completes
        md_seq(rtype(5'd9, 5'd1, 5'd2, 5'd6), 99, 1'b0, "mul_tmo", stall_cnt);
        chk_int("mul_tmo_stall_cycles", stall_cnt, 41);
        tick();
        chk("timeout_one_cycle", sample(), '0);

        // mul completing with an exception
        md_seq(rtype(5'd9, 5'd1, 5'd2, 5'd6), 3, 1'b1, "mul_exc", stall_cnt);
        // div with exception
        md_seq(rtype(5'd13, 5'd1, 5'd2, 5'd7), 0, 1'b1, "div_exc", stall_cnt);
        // md_ready coincident with the timeout: completion wins
        md_seq(rtype(5'd14, 5'd1, 5'd2, 5'd6), TMO, 1'b0, "mul_race", stall_cnt);

        // Reset during MD_WAIT: operation abandoned, never reissued
        insn_in = rtype(5'd11, 5'd1, 5'd2, 5'd6); insn_valid = 1'b1;
        tick();
        insn_valid = 1'b0;
        repeat (5) tick();
        #2 reset_n = 1'b0;
        #1 chk("reset_in_mdwait", sample(), '0);
        tick();
        reset_n = 1'b1;
        md_ready = 1'b1; md_exception = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("no_reissue", sample(), '0);
        end
        md_ready = 1'b0; md_exception = 1'b0;
        insn_in = mk(T_ADDI, 5'd3, 5'd0, 17'h00001); insn_valid = 1'b1;
        tick();
        chk("decode_after_md_reset", sample(), ev(1,0,1,0,0,1,5'd0,0,0,5'd3));
        $display("[TB] reset during MD_WAIT: out=%h", sample());

        // Randomized stream against the reference model
        for (int it = 0; it < 300; it++) begin
            logic [31:0] ins;
            logic [4:0]  op;
            logic        vld;
            if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
            else                           op = known_ops[$urandom_range(0, 10)];
            ins = {op, 27'($urandom)};
            if (op == T_R && $urandom_range(0, 2) == 0)
                ins[6:2] = ($urandom_range(0, 1) == 1) ? 5'd7 : 5'd6;
            vld = ($urandom_range(0, 4) != 0);
            if (vld && op == T_R && (ins[6:2] == 5'd6 || ins[6:2] == 5'd7)) begin
                md_seq(ins, $urandom_range(0, 45), 1'($urandom_range(0, 1)), "rnd_md", stall_cnt);
            end else begin
                insn_in = ins; insn_valid = vld;
                md_ready = 1'($urandom_range(0, 1)); md_exception = 1'($urandom_range(0, 1));
                tick();
                chk("rnd_decode", sample(), vld ? model_decode(ins) : out_t'('0));
                $display("[TB] rnd %0d insn=%h valid=%0d out=%h", it, ins, vld, sample());
            end
        end
        md_ready = 1'b0; md_exception = 1'b0; insn_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
